rxll_ll: RTL and testbench
==========================

// Module: rxll_ll
// PURPOSE
//  SATA receive link-layer sink, the receive-side counterpart of the transmit link path.
//  Accepts LocalLink frames (trn_r*) from the link/PHY side on phyclk.
//  Stores them in an internal single-clock frame buffer, tagged with sof/eof/err.
//  Presents them to the transport layer as a first-word-fall-through (FWFT) read port with a
//  complete-frame indicator. Flow control on trn_rdst_rdy_n prevents overflow; aborted or
//  malformed frames are closed with an error-tagged eof entry.
// PARAMETERS
//  C_DEPTH_LOG2    9   buffer depth = 2**C_DEPTH_LOG2 entries of 35 bits {err,sof,eof,data[31:0]}
//  C_AFULL_MARGIN  4   free entries below which trn_rdst_rdy_n is driven high; legal range >=3
// PORTS
//  phyclk          in   1   sole clock
//  phyreset_n      in   1   asynchronous active-low reset
//  trn_rd          in   32  LocalLink data
//  trn_rsof_n      in   1   start of frame, active low
//  trn_reof_n      in   1   end of frame, active low
//  trn_rsrc_rdy_n  in   1   source ready, active low
//  trn_rsrc_dsc_n  in   1   source discontinue, active low
//  trn_rdst_rdy_n  out  1   destination ready, active low, registered
//  trn_rdst_dsc_n  out  1   destination discontinue, active low, registered
//  rxfifo_flush    in   1   discard buffer contents and any frame in progress
//  rxfifo_rd_en    in   1   pop the head entry; ignored when rxfifo_empty
//  rxfifo_data     out  32  head entry data (FWFT)
//  rxfifo_sof      out  1   head entry is the first word of a frame
//  rxfifo_eof      out  1   head entry is the last word of a frame
//  rxfifo_err      out  1   head entry closes a frame abnormally
//  rxfifo_empty    out  1   no entry available at the head
//  rxfifo_count    out  C_DEPTH_LOG2+1  entries held, including the output register
//  rxfifo_eof_rdy  out  1   at least one complete frame (eof written, not yet popped)
//  rx_proto_err    out  1   one-cycle pulse on any protocol violation
// BEHAVIOUR
//  Reset values
//   trn_rdst_rdy_n=1, trn_rdst_dsc_n=1, rxfifo_empty=1, rxfifo_count=0.
//   rxfifo_eof_rdy=0, rx_proto_err=0, data/flag outputs=0; state=IDLE; pointers=0.
//  Beat acceptance: beat = !trn_rsrc_rdy_n && !trn_rdst_rdy_n.
//  Flow control: trn_rdst_rdy_n <= (free_next < C_AFULL_MARGIN).
//   free_next is the free-entry count after this cycle's write/pop.
//   Because ready is registered, the margin guarantees room for in-flight beats plus one fixup entry.
//  States
//   IDLE
//    - beat with sof: write {0,1,eof,data}. Stay in IDLE if eof, otherwise go to FRAME.
//    - beat without sof: drop the beat and pulse rx_proto_err.
//   FRAME
//    - beat, no sof: write {0,0,eof,data}. eof -> IDLE.
//    - beat with sof: write {1,0,1,data} to close the old frame with an error.
//      Pulse rx_proto_err and go to IDLE. The new frame's later beats are dropped as no-sof.
//    - trn_rsrc_dsc_n low with a beat: write {1,0,1,data} -> IDLE.
//    - trn_rsrc_dsc_n low without a beat: go to FIXUP.
//   FIXUP
//    - write synthetic {1,0,1,32'h0} on the next cycle (always has space) -> IDLE.
//    - trn_rdst_rdy_n is forced high while in FIXUP.
//  trn_rsrc_dsc_n low while in IDLE is ignored.
//  FWFT read port
//   - A write into an empty buffer is visible at the head (rxfifo_empty=0) 2 cycles later.
//   - rxfifo_rd_en with !rxfifo_empty: the next entry is presented on the following cycle,
//     with no bubble when the RAM is non-empty.
//   - Simultaneous write and pop: count unchanged.
//   - Pop while empty: no effect.
//  Frame counter: +1 when an eof entry is written, -1 when an eof entry is popped,
//   unchanged on both. rxfifo_eof_rdy = (frame counter != 0).
//  Pointers wrap modulo 2**C_DEPTH_LOG2. Count width holds the full value 2**C_DEPTH_LOG2.
//  rxfifo_flush (synchronous, one cycle)
//   - clears pointers, output register, count and frame counter; state -> IDLE;
//     any beat accepted in the same cycle is dropped.
//   - If state was FRAME or FIXUP, trn_rdst_dsc_n is low for exactly the next cycle.
//  Asynchronous reset mid-frame: all state is lost, and the partial frame never appears at the read port.
// TESTING
//  1. 4-beat frame 0xA0..0xA3 (sof on A0, eof on A3)
//     -> rxfifo_eof_rdy=1 after eof is written; 4 pops return A0(sof)..A3(eof), err=0; count ends at 0.
//  2. Source dsc while in FRAME after 2 beats, no beat that cycle
//     -> 3 entries; last is {err=1,eof=1,data=0}; rx_proto_err stays 0.
//  3. C_DEPTH_LOG2=4, C_AFULL_MARGIN=4, no reads, continuous 20-beat frame
//     -> trn_rdst_rdy_n=1 once free<4; no overflow; rxfifo_count<=16.
//  4. Beat without sof in IDLE, then sof in FRAME
//     -> each pulses rx_proto_err; the second closes the frame with {err=1,eof=1}.
//  5. rxfifo_flush mid-frame with 3 entries buffered
//     -> next cycle count=0, empty=1, trn_rdst_dsc_n=0 for exactly one cycle.
//  6. Pop the eof entry while a new eof entry is written in the same cycle
//     -> frame counter unchanged; rxfifo_eof_rdy stays 1.

Source files
------------

// File: rtl/rxll_ll.sv
// Receive link-layer sink: LocalLink frames in, tagged FWFT frame buffer out.
// Each entry is {err, sof, eof, data[31:0]}. Malformed or aborted frames are
// closed with an err+eof entry, so the reader always sees complete frames.
module rxll_ll #(
  parameter int C_DEPTH_LOG2   = 9,
  parameter int C_AFULL_MARGIN = 4
) (
  input  logic                    phyclk,
  input  logic                    phyreset_n,
  input  logic [31:0]             trn_rd,
  input  logic                    trn_rsof_n,
  input  logic                    trn_reof_n,
  input  logic                    trn_rsrc_rdy_n,
  input  logic                    trn_rsrc_dsc_n,
  output logic                    trn_rdst_rdy_n,
  output logic                    trn_rdst_dsc_n,
  input  logic                    rxfifo_flush,
  input  logic                    rxfifo_rd_en,
  output logic [31:0]             rxfifo_data,
  output logic                    rxfifo_sof,
  output logic                    rxfifo_eof,
  output logic                    rxfifo_err,
  output logic                    rxfifo_empty,
  output logic [C_DEPTH_LOG2:0]   rxfifo_count,
  output logic                    rxfifo_eof_rdy,
  output logic                    rx_proto_err
);

  localparam int AW    = C_DEPTH_LOG2;
  localparam int CW    = C_DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** C_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, FIXUP = 2'd2} state_t;

  state_t         state_q, state_d;
  logic           rdy_n_q, rdy_n_d;
  logic           dsc_n_q, dsc_n_d;
  logic           perr_q, perr_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           out_valid_q, out_valid_d;
  logic [34:0]    out_entry_q, out_entry_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  eof_cnt_q, eof_cnt_d;

  logic [34:0]    mem [DEPTH];

  logic           beat, src_dsc, is_sof, is_eof;
  logic           wr_en;
  logic [34:0]    wr_entry;
  logic           ram_empty, pop, load;
  logic [CW-1:0]  free_next;

  assign beat    = !trn_rsrc_rdy_n && !rdy_n_q;
  assign src_dsc = !trn_rsrc_dsc_n;
  assign is_sof  = !trn_rsof_n;
  assign is_eof  = !trn_reof_n;

  // State register and all pointer/flag flops
  always_ff @(posedge phyclk or negedge phyreset_n) begin
    if (!phyreset_n) begin
      state_q     <= IDLE;
      rdy_n_q     <= 1'b1;
      dsc_n_q     <= 1'b1;
      perr_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      count_q     <= '0;
      eof_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rdy_n_q     <= rdy_n_d;
      dsc_n_q     <= dsc_n_d;
      perr_q      <= perr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
      count_q     <= count_d;
      eof_cnt_q   <= eof_cnt_d;
    end
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (beat && is_sof && !is_eof) state_d = FRAME;
      end
      FRAME: begin
        if (beat) begin
          if (is_sof || src_dsc || is_eof) state_d = IDLE;
        end else if (src_dsc) begin
          state_d = FIXUP;
        end
      end
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rxfifo_flush) state_d = IDLE;
  end

  // FSM outputs: buffer write request and protocol-error pulse
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = '0;
    perr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (is_sof) begin
            wr_en    = 1'b1;
            wr_entry = {1'b0, 1'b1, is_eof, trn_rd};
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      FRAME: begin
        if (beat) begin
          wr_en = 1'b1;
          if (is_sof) begin
            wr_entry = {1'b1, 1'b0, 1'b1, trn_rd};
            perr_d   = 1'b1;
          end else if (src_dsc) begin
            wr_entry = {1'b1, 1'b0, 1'b1, trn_rd};
          end else begin
            wr_entry = {1'b0, 1'b0, is_eof, trn_rd};
          end
        end
      end
      FIXUP: begin
        wr_en    = 1'b1;
        wr_entry = {1'b1, 1'b0, 1'b1, 32'h0};
      end
      default: ;
    endcase
    if (rxfifo_flush) begin
      wr_en  = 1'b0;
      perr_d = 1'b0;
    end
  end

  // Buffer storage; read side goes through the registered head entry
  always_ff @(posedge phyclk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign pop       = rxfifo_rd_en && out_valid_q;
  assign load      = !ram_empty && (!out_valid_q || pop);

  // FWFT head refill, occupancy, frame count and link-side flow control
  always_comb begin
    wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(load);
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_entry_d = mem[rd_ptr_q[AW-1:0]];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    count_d   = count_q + CW'(wr_en) - CW'(pop);
    eof_cnt_d = eof_cnt_q + CW'(wr_en && wr_entry[32]) - CW'(pop && out_entry_q[32]);
    dsc_n_d   = 1'b1;
    if (rxfifo_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      out_entry_d = '0;
      count_d     = '0;
      eof_cnt_d   = '0;
      dsc_n_d     = (state_q == IDLE);
    end
    free_next = CW'(DEPTH) - count_d;
    rdy_n_d   = ({1'b0, free_next} < (CW+1)'(C_AFULL_MARGIN)) || (state_d == FIXUP);
  end

  assign trn_rdst_rdy_n = rdy_n_q;
  assign trn_rdst_dsc_n = dsc_n_q;
  assign rx_proto_err   = perr_q;
  assign rxfifo_err     = out_entry_q[34];
  assign rxfifo_sof     = out_entry_q[33];
  assign rxfifo_eof     = out_entry_q[32];
  assign rxfifo_data    = out_entry_q[31:0];
  assign rxfifo_empty   = !out_valid_q;
  assign rxfifo_count   = count_q;
  assign rxfifo_eof_rdy = (eof_cnt_q != '0);

endmodule

// File: tb/tb_rxll_ll.sv
// Bench for rxll_ll: directed scenarios followed by random traffic, every
// cycle compared against a frame-level reference model built on a queue.
module tb_rxll_ll;

  localparam int LOG2   = 4;
  localparam int DEPTH  = 2 ** LOG2;
  localparam int MARGIN = 4;

  logic        phyclk = 1'b0;
  logic        phyreset_n = 1'b0;
  logic [31:0] trn_rd = '0;
  logic        trn_rsof_n = 1'b1, trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1, trn_rsrc_dsc_n = 1'b1;
  logic        trn_rdst_rdy_n, trn_rdst_dsc_n;
  logic        rxfifo_flush = 1'b0, rxfifo_rd_en = 1'b0;
  logic [31:0] rxfifo_data;
  logic        rxfifo_sof, rxfifo_eof, rxfifo_err, rxfifo_empty;
  logic [LOG2:0] rxfifo_count;
  logic        rxfifo_eof_rdy, rx_proto_err;

  rxll_ll #(.C_DEPTH_LOG2(LOG2), .C_AFULL_MARGIN(MARGIN)) dut (
    .phyclk(phyclk), .phyreset_n(phyreset_n),
    .trn_rd(trn_rd), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rsrc_dsc_n(trn_rsrc_dsc_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rdst_dsc_n(trn_rdst_dsc_n),
    .rxfifo_flush(rxfifo_flush), .rxfifo_rd_en(rxfifo_rd_en),
    .rxfifo_data(rxfifo_data), .rxfifo_sof(rxfifo_sof), .rxfifo_eof(rxfifo_eof),
    .rxfifo_err(rxfifo_err), .rxfifo_empty(rxfifo_empty), .rxfifo_count(rxfifo_count),
    .rxfifo_eof_rdy(rxfifo_eof_rdy), .rx_proto_err(rx_proto_err)
  );

  always #5 phyclk = ~phyclk;

  // Stimulus intent for the next cycle (active-high for readability)
  logic [31:0] s_rd = '0;
  bit s_sof, s_eof, s_src, s_dsc, s_flush, s_rden;

  // Reference model: receive state, entries written but not yet popped,
  // and the registered link-side outputs
  typedef enum int {M_IDLE, M_FRAME, M_FIXUP} mstate_t;
  typedef struct { logic [34:0] e; int t; } ent_t;
  ent_t    q[$];
  mstate_t m_st = M_IDLE;
  bit      m_rdy_n = 1, m_dsc_n = 1, m_perr = 0;
  int      cyc = 0;
  bit      acc;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit head_vis();
    return (q.size() > 0) && (cyc >= q[0].t + 2);
  endfunction

  function automatic int eofs_held();
    int n = 0;
    foreach (q[i]) if (q[i].e[32]) n++;
    return n;
  endfunction

  task automatic check_outputs();
    bit vis = head_vis();
    chk("count",   rxfifo_count, q.size());
    chk("empty",   rxfifo_empty, !vis);
    chk("eof_rdy", rxfifo_eof_rdy, eofs_held() != 0);
    chk("rdy_n",   trn_rdst_rdy_n, m_rdy_n);
    chk("dsc_n",   trn_rdst_dsc_n, m_dsc_n);
    chk("perr",    rx_proto_err, m_perr);
    if (vis) chk("head", {rxfifo_err, rxfifo_sof, rxfifo_eof, rxfifo_data}, q[0].e);
  endtask

  task automatic model_step();
    bit beat, pop, push;
    logic [34:0] e;
    ent_t x;
    beat = s_src && !m_rdy_n;
    acc  = beat;
    pop  = s_rden && head_vis();
    push = 0;
    e    = '0;
    m_perr  = 0;
    m_dsc_n = 1;
    if (s_flush) begin
      m_dsc_n = (m_st == M_IDLE);
      q.delete();
      m_st = M_IDLE;
    end else begin
      if (pop) void'(q.pop_front());
      case (m_st)
        M_IDLE: if (beat) begin
          if (s_sof) begin
            push = 1; e = {1'b0, 1'b1, s_eof, s_rd};
            m_st = s_eof ? M_IDLE : M_FRAME;
          end else m_perr = 1;
        end
        M_FRAME: begin
          if (beat && s_sof) begin
            push = 1; e = {1'b1, 1'b0, 1'b1, s_rd}; m_perr = 1; m_st = M_IDLE;
          end else if (beat && s_dsc) begin
            push = 1; e = {1'b1, 1'b0, 1'b1, s_rd}; m_st = M_IDLE;
          end else if (beat) begin
            push = 1; e = {1'b0, 1'b0, s_eof, s_rd};
            if (s_eof) m_st = M_IDLE;
          end else if (s_dsc) m_st = M_FIXUP;
        end
        default: begin
          push = 1; e = {1'b1, 1'b0, 1'b1, 32'h0}; m_st = M_IDLE;
        end
      endcase
    end
    if (push) begin x.e = e; x.t = cyc; q.push_back(x); end
    m_rdy_n = ((DEPTH - q.size()) < MARGIN) || (m_st == M_FIXUP);
    cyc++;
  endtask

  // One clock: drive at negedge, advance model, check at the next negedge
  task automatic tick();
    trn_rd         = s_rd;
    trn_rsof_n     = !s_sof;
    trn_reof_n     = !s_eof;
    trn_rsrc_rdy_n = !s_src;
    trn_rsrc_dsc_n = !s_dsc;
    rxfifo_flush   = s_flush;
    rxfifo_rd_en   = s_rden;
    model_step();
    @(negedge phyclk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    s_rd = '0; s_sof = 0; s_eof = 0; s_src = 0; s_dsc = 0; s_flush = 0; s_rden = 0;
  endtask

  task automatic send(input logic [31:0] d, input bit sof, input bit eof);
    int n = 0;
    s_rd = d; s_sof = sof; s_eof = eof; s_src = 1;
    do begin tick(); n++; end while (!acc && n < 64);
    if (!acc) chk("send_timeout", 0, 1);
    s_src = 0; s_sof = 0; s_eof = 0;
  endtask

  task automatic drain();
    int n = 0;
    s_rden = 1;
    while (q.size() > 0 && n < 80) begin tick(); n++; end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    s_rden = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    trn_rsrc_rdy_n = 1; trn_rsof_n = 1; trn_reof_n = 1; trn_rsrc_dsc_n = 1;
    rxfifo_flush = 0; rxfifo_rd_en = 0;
    #1 phyreset_n = 0;
    q.delete(); m_st = M_IDLE; m_rdy_n = 1; m_dsc_n = 1; m_perr = 0;
    #1;
    chk("rst_count", rxfifo_count, 0);
    chk("rst_empty", rxfifo_empty, 1);
    chk("rst_rdy_n", trn_rdst_rdy_n, 1);
    chk("rst_flags", {rxfifo_err, rxfifo_sof, rxfifo_eof, rxfifo_data, rxfifo_eof_rdy, rx_proto_err, trn_rdst_dsc_n}, 1);
    repeat (2) @(posedge phyclk);
    #2 phyreset_n = 1;
    @(negedge phyclk);
    check_outputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge phyclk);
    do_reset();

    // 1: four-beat frame then read it back
    send(32'hA0, 1, 0); send(32'hA1, 0, 0); send(32'hA2, 0, 0); send(32'hA3, 0, 1);
    tick(); tick();
    chk("t1_eof_rdy", rxfifo_eof_rdy, 1);
    drain();
    chk("t1_count_end", rxfifo_count, 0);

    // 2: source discontinue with no beat -> synthetic error eof
    send(32'hB0, 1, 0); send(32'hB1, 0, 0);
    s_dsc = 1; tick(); s_dsc = 0;
    tick(); tick(); tick();
    chk("t2_entries", q.size(), 3);
    chk("t2_last", q[2].e, {3'b101, 32'h0});
    drain();

    // 3: continuous long frame with no reads must stall, never overflow
    s_src = 1; s_sof = 1; s_rd = 32'hC00;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("t3_cnt_le", rxfifo_count <= DEPTH, 1);
      if (acc) begin s_sof = 0; s_rd = s_rd + 1; end
    end
    chk("t3_stalled", trn_rdst_rdy_n, 1);
    idle_inputs();

    // 5: flush mid-frame (buffer already holds the stalled frame)
    s_flush = 1; tick(); s_flush = 0;
    chk("t5_count", rxfifo_count, 0);
    chk("t5_dsc_lo", trn_rdst_dsc_n, 0);
    tick();
    chk("t5_dsc_hi", trn_rdst_dsc_n, 1);
    send(32'hD0, 1, 0); send(32'hD1, 0, 0); send(32'hD2, 0, 0);
    tick(); tick();
    s_flush = 1; tick(); s_flush = 0;
    chk("t5b_empty", rxfifo_empty, 1);
    chk("t5b_dsc_lo", trn_rdst_dsc_n, 0);
    tick();

    // 4: no-sof beat in IDLE, then sof inside a frame
    send(32'hE0, 0, 0);
    chk("t4_perr1", rx_proto_err, 1);
    send(32'hE1, 1, 0); send(32'hE2, 1, 0);
    chk("t4_perr2", rx_proto_err, 1);
    tick(); tick();
    drain();

    // 6: pop an eof entry while another eof entry is written
    send(32'hF0, 1, 1);
    tick(); tick();
    s_rden = 1; s_rd = 32'hF1; s_sof = 1; s_eof = 1; s_src = 1;
    tick();
    chk("t6_acc", acc, 1);
    chk("t6_eof_rdy", rxfifo_eof_rdy, 1);
    idle_inputs();
    tick(); drain();

    // Asynchronous reset in the middle of a frame
    send(32'h50, 1, 0); send(32'h51, 0, 0);
    do_reset();
    tick(); tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      s_rd    = $urandom;
      s_src   = ($urandom_range(0, 3) != 0);
      s_sof   = ($urandom_range(0, 5) == 0);
      s_eof   = ($urandom_range(0, 4) == 0);
      s_dsc   = ($urandom_range(0, 30) == 0);
      s_flush = ($urandom_range(0, 200) == 0);
      s_rden  = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      tick();
    end
    idle_inputs();
    tick(); tick();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
